// File: rtl/gouraud_step_capture_if.sv
// Phrase write-data handshake between the step-capture FIFO and its consumer.
// Lane n of out_data occupies bits [WIDTH*n + WIDTH-1 : WIDTH*n].
interface gouraud_step_capture_if #(
    parameter int WIDTH = 16
);
    logic                 out_valid;
    logic                 out_ready;
    logic [4*WIDTH-1:0]   out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/gouraud_step_capture.sv
// Running four-lane Gouraud/Z phrase accumulator: feeds the adder array, captures its
// sums on each step and queues the pre-step phrase into a small output FIFO.
module gouraud_step_capture #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic                   init_ld,
    input  logic [4*WIDTH-1:0]     init_data,
    input  logic                   start,
    input  logic [CNT_W-1:0]       count,
    input  logic [WIDTH-1:0]       addq_0,
    input  logic [WIDTH-1:0]       addq_1,
    input  logic [WIDTH-1:0]       addq_2,
    input  logic [WIDTH-1:0]       addq_3,
    output logic [WIDTH-1:0]       feed_0,
    output logic [WIDTH-1:0]       feed_1,
    output logic [WIDTH-1:0]       feed_2,
    output logic [WIDTH-1:0]       feed_3,
    output logic                   step,
    output logic                   busy,
    output logic                   done,
    gouraud_step_capture_if.master out_if
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FCNT_W = PTR_W + 1;
    localparam logic [FCNT_W-1:0] DEPTH_C = FCNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               state_r;
    logic [4*WIDTH-1:0]   acc_r;
    logic [CNT_W-1:0]     remaining_r;
    logic [4*WIDTH-1:0]   mem_r [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [FCNT_W-1:0]    fifo_cnt_r;
    logic                 done_r;
    logic                 push_s;
    logic                 pop_s;

    // Pop on handshake; a push may reuse the slot freed by this cycle's pop.
    always_comb begin
        pop_s  = (fifo_cnt_r != {FCNT_W{1'b0}}) && out_if.out_ready;
        push_s = 1'b0;
        if (state_r == ST_RUN) begin
            push_s = (fifo_cnt_r < DEPTH_C) || pop_s;
        end else begin
            push_s = 1'b0;
        end
    end

    assign feed_0           = acc_r[0*WIDTH +: WIDTH];
    assign feed_1           = acc_r[1*WIDTH +: WIDTH];
    assign feed_2           = acc_r[2*WIDTH +: WIDTH];
    assign feed_3           = acc_r[3*WIDTH +: WIDTH];
    assign step             = push_s;
    assign busy             = (state_r != ST_IDLE);
    assign done             = done_r;
    assign out_if.out_valid = (fifo_cnt_r != {FCNT_W{1'b0}});
    assign out_if.out_data  = mem_r[rd_ptr_r];

    // Control FSM, accumulator and output FIFO state.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            acc_r       <= {(4*WIDTH){1'b0}};
            remaining_r <= {CNT_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            fifo_cnt_r  <= {FCNT_W{1'b0}};
            done_r      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {(4*WIDTH){1'b0}};
            end
        end else begin
            done_r <= 1'b0;
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (push_s) begin
                mem_r[wr_ptr_r] <= acc_r;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            fifo_cnt_r <= fifo_cnt_r + FCNT_W'(push_s) - FCNT_W'(pop_s);

            case (state_r)
                ST_IDLE: begin
                    if (init_ld) begin
                        acc_r <= init_data;
                    end
                    if (start) begin
                        remaining_r <= count;
                        state_r     <= (count != {CNT_W{1'b0}}) ? ST_RUN : ST_DRAIN;
                    end
                end
                ST_RUN: begin
                    if (push_s) begin
                        acc_r       <= {addq_3, addq_2, addq_1, addq_0};
                        remaining_r <= remaining_r - CNT_W'(1);
                        if (remaining_r == CNT_W'(1)) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Finish as soon as the FIFO is, or is about to be, empty.
                    if ((fifo_cnt_r == {FCNT_W{1'b0}}) ||
                        ((fifo_cnt_r == FCNT_W'(1)) && pop_s)) begin
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/gouraud_step_capture.md
Name: gouraud_step_capture

Overview:
- Sits directly downstream of the blitter four-lane 16-bit adder array.
- Holds the running 64-bit phrase accumulator (four 16-bit lanes of intensity/Z) and drives it back as the adder's A operand.
- Each step captures the adder sums into the accumulator and pushes the pre-step phrase into a small output FIFO.
- The FIFO feeds the phrase write-data path over a valid/ready handshake.

Parameters:
- WIDTH, 16, lane width in bits.
- DEPTH, 2, output FIFO entries (power of two, ≥2).
- CNT_W, 16, step counter width.

Ports:
- sys_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- init_ld  in  1  load accumulator from init_data (IDLE only).
- init_data  in  4*WIDTH  initial phrase; lane n = bits [16n+15:16n].
- start  in  1  begin a run (IDLE only).
- count  in  CNT_W  number of phrases to emit; sampled on start.
- addq_0..addq_3  in  WIDTH each  adder-array sums, combinational from feed_n.
- feed_0..feed_3  out  WIDTH each  accumulator lanes, wired to adder A inputs.
- step  out  1  high in each cycle the accumulator advances.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  4*WIDTH  FIFO head; lane packing as init_data.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at run completion.

Behaviour:
Reset
- Accumulator, FIFO, counter, out_valid, step, busy and done all cleared to 0; state goes to IDLE.
- Reset mid-run discards FIFO contents with no done pulse.

States: IDLE, RUN, DRAIN.

IDLE
- init_ld=1: acc <= init_data on the next edge.
- start=1: remaining <= count.
  - count != 0: go to RUN.
  - count == 0: go to DRAIN; done pulses once the FIFO is empty, with no pushes.
- init_ld and start in the same cycle: load first, start is honoured; the first push is init_data.

RUN
- Push condition: fifo_cnt < DEPTH, counting this cycle's pop as already freeing a slot (simultaneous push and pop when full is allowed).
- On push:
  - FIFO <= acc.
  - acc <= {addq_3, addq_2, addq_1, addq_0}.
  - remaining <= remaining - 1.
  - step = 1 (combinational, same cycle).
- No push: acc and remaining hold; step = 0.
- When a push makes remaining == 0: go to DRAIN.
- start and init_ld are ignored while busy.

DRAIN
- No pushes; step = 0.
- When the FIFO becomes empty (including via a pop this cycle): done = 1 for one cycle, state goes to IDLE.
- The accumulator retains its final value, one step beyond the last emitted phrase.

FIFO
- out_valid = (fifo_cnt != 0).
- A pop occurs on out_valid && out_ready.
- out_data is stable while out_valid && !out_ready.
- Pointers wrap modulo DEPTH.
- No overflow is possible by construction; out_ready with an empty FIFO has no effect.

Arithmetic
- This block does no arithmetic. Lane wrap and saturation belong to the adder array; the captured value is exactly addq_n.

Latency
- A phrase is visible on out_data one cycle after its push.
- Throughput is one phrase per cycle with out_ready held high.

Test Plan:
1. init_ld with init_data=0x0004_0003_0002_0001; adder configured as +1 per lane; start, count=3, out_ready=1.
   -> out_data sequence 0x0004_0003_0002_0001, 0x0005_0004_0003_0002, 0x0006_0005_0004_0003; step high for 3 cycles; done one cycle after last pop; acc=0x0007_0006_0005_0004.
2. count=5 with out_ready=0 for 6 cycles, then 1.
   -> step high exactly 2 cycles then stalls; out_data holds the first phrase; all 5 phrases delivered in order after release.
3. start with count=0.
   -> no out_valid, no step; done pulses; back to IDLE; busy high for no more than 2 cycles.
4. FIFO full (2 entries), out_ready=1 in the same cycle as a push request.
   -> push and pop both occur; fifo_cnt stays 2; no phrase lost or duplicated.
5. Lane wrap: lane0=0xFFFF, addq_0=0x0000.
   -> second phrase lane0=0x0000; lanes independent.
6. reset asserted mid-RUN with 1 entry queued.
   -> next cycle out_valid=0, busy=0, feed_n=0, no done pulse; start asserted in the same cycle as init_ld during RUN is ignored.
